// File: rtl/frame_reader_pkg.sv
// Shared definitions for the frame reader DMA: register map, CTRL/STATUS bit
// positions and the read-side FSM states.
package frame_reader_pkg;

    localparam logic [1:0] REG_BASE   = 2'd0;
    localparam logic [1:0] REG_LENGTH = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_CONT   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

endpackage

// File: rtl/frame_reader_fifo.sv
// Single-clock show-ahead FIFO: o_dout presents the head entry whenever the
// FIFO is non-empty. A push while full is taken only if a pop happens too.
module frame_reader_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/frame_reader_dma.sv
// Avalon-MM burst read master that fetches a frame from memory and streams it
// out as tagged pixel words, configured through a 4-register slave.
module frame_reader_dma
    import frame_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    as_address,
    input  logic                          as_read,
    input  logic                          as_write,
    input  logic [31:0]                   as_writedata,
    output logic [31:0]                   as_readdata,
    output logic [ADDR_WIDTH-1:0]         am_address,
    output logic                          am_read,
    output logic [$clog2(BURST_LEN):0]    am_burstcount,
    input  logic                          am_waitrequest,
    input  logic [DATA_WIDTH-1:0]         am_readdata,
    input  logic                          am_readdatavalid,
    output logic [DATA_WIDTH-1:0]         pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_sof,
    output logic                          pix_eof,
    output logic                          irq
);
    localparam int unsigned BCW = $clog2(BURST_LEN) + 1;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

    state_t                  r_state;
    state_t                  w_next;
    logic [31:0]             r_base;
    logic [31:0]             r_length;
    logic                    r_cont;
    logic                    r_irq_en;
    logic                    r_done;
    logic [31:0]             r_readdata;
    logic [ADDR_WIDTH-1:0]   r_sh_base;
    logic [31:0]             r_sh_len;
    logic [31:0]             r_issued;
    logic [31:0]             r_ret;
    logic [CW-1:0]           r_outstanding;
    logic                    r_eof_acc;

    logic                    w_start;
    logic                    w_load;
    logic                    w_restart;
    logic                    w_frame_done;
    logic                    w_accept;
    logic                    w_last_burst;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_eof_pop;
    logic                    w_busy;
    logic                    w_am_read;
    logic [31:0]             w_remaining;
    logic [BCW-1:0]          w_bc;
    logic [CW-1:0]           w_room;
    logic [CW-1:0]           w_fifo_count;
    logic                    w_fifo_empty;
    logic [DATA_WIDTH+1:0]   w_fifo_dout;
    logic [DATA_WIDTH+1:0]   w_fifo_din;
    logic [31:0]             w_rd_mux;

    assign w_start      = as_write && (as_address == REG_CTRL) &&
                          as_writedata[CTRL_START] && (r_state == IDLE);
    assign w_remaining  = r_sh_len - r_issued;
    assign w_bc         = (w_remaining >= 32'(BURST_LEN)) ? BCW'(BURST_LEN) : BCW'(w_remaining);
    // Space not yet claimed by words in the FIFO or already requested.
    assign w_room       = CW'(FIFO_DEPTH) - (w_fifo_count + r_outstanding);
    assign w_accept     = w_am_read && !am_waitrequest;
    assign w_last_burst = w_accept && ((r_issued + 32'(w_bc)) == r_sh_len);
    assign w_push       = am_readdatavalid && (r_outstanding != '0);
    assign w_pop        = !w_fifo_empty && pix_ready;
    assign w_eof_pop    = w_pop && w_fifo_dout[DATA_WIDTH];
    assign w_frame_done = (r_state == DRAIN) && (r_outstanding == '0) && (r_eof_acc || w_eof_pop);
    assign w_restart    = w_frame_done && r_cont && (r_length != '0);
    assign w_load       = (w_start && (r_length != '0)) || w_restart;
    assign w_fifo_din   = {(r_ret == '0), (r_ret == (r_sh_len - 32'd1)), am_readdata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start && (r_length != '0)) w_next = ISSUE;
            ISSUE:   if (w_last_burst) w_next = DRAIN;
            DRAIN:   if (w_frame_done) w_next = w_restart ? ISSUE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy        = (r_state != IDLE);
        w_am_read     = 1'b0;
        am_address    = '0;
        am_burstcount = '0;
        if (r_state == ISSUE) begin
            w_am_read     = (w_room >= CW'(w_bc));
            am_address    = r_sh_base + ADDR_WIDTH'({r_issued, 2'b00});
            am_burstcount = w_bc;
        end
    end

    assign am_read = w_am_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base   <= '0;
            r_length <= '0;
            r_cont   <= 1'b0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (as_write && (as_address == REG_BASE))
                r_base <= {as_writedata[31:2], 2'b00};
            if (as_write && (as_address == REG_LENGTH))
                r_length <= as_writedata;
            if (as_write && (as_address == REG_CTRL)) begin
                r_cont   <= as_writedata[CTRL_CONT];
                r_irq_en <= as_writedata[CTRL_IRQ_EN];
            end
            if (w_frame_done || (w_start && (r_length == '0)))
                r_done <= 1'b1;
            else if (as_write && (as_address == REG_STATUS) && as_writedata[STAT_DONE])
                r_done <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_base     <= '0;
            r_sh_len      <= '0;
            r_issued      <= '0;
            r_ret         <= '0;
            r_outstanding <= '0;
            r_eof_acc     <= 1'b0;
        end else begin
            if (w_load) begin
                r_sh_base <= ADDR_WIDTH'(r_base);
                r_sh_len  <= r_length;
                r_issued  <= '0;
                r_ret     <= '0;
                r_eof_acc <= 1'b0;
            end else begin
                if (w_accept)
                    r_issued <= r_issued + 32'(w_bc);
                if (w_push)
                    r_ret <= r_ret + 32'd1;
                if (w_eof_pop)
                    r_eof_acc <= 1'b1;
            end
            r_outstanding <= r_outstanding + (w_accept ? CW'(w_bc) : '0) - (w_push ? CW'(1) : '0);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (as_address)
            REG_BASE:   w_rd_mux = r_base;
            REG_LENGTH: w_rd_mux = r_length;
            REG_CTRL: begin
                w_rd_mux[CTRL_CONT]   = r_cont;
                w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
            end
            default: begin
                w_rd_mux[STAT_BUSY] = w_busy;
                w_rd_mux[STAT_DONE] = r_done;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_readdata <= '0;
        else
            r_readdata <= as_read ? w_rd_mux : '0;
    end

    assign as_readdata = r_readdata;
    assign irq         = r_done && r_irq_en;
    assign pix_valid   = !w_fifo_empty;
    assign pix_data    = pix_valid ? w_fifo_dout[DATA_WIDTH-1:0] : '0;
    assign pix_eof     = pix_valid && w_fifo_dout[DATA_WIDTH];
    assign pix_sof     = pix_valid && w_fifo_dout[DATA_WIDTH+1];

    frame_reader_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_frame_reader_dma.sv
// Scoreboard bench for frame_reader_dma: a memory/fabric model answers bursts,
// a stream monitor pops expected pixel words as the sink accepts them.
module tb_frame_reader_dma;
    import frame_reader_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BL  = 8;
    localparam int FD  = 64;
    localparam int BCW = 4;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [BCW-1:0] bc;
    } burst_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [1:0]     as_address = '0;
    logic           as_read = 1'b0;
    logic           as_write = 1'b0;
    logic [31:0]    as_writedata = '0;
    logic [31:0]    as_readdata;
    logic [AW-1:0]  am_address;
    logic           am_read;
    logic [BCW-1:0] am_burstcount;
    logic           am_waitrequest = 1'b0;
    logic [DW-1:0]  am_readdata = '0;
    logic           am_readdatavalid = 1'b0;
    logic [DW-1:0]  pix_data;
    logic           pix_valid;
    logic           pix_ready = 1'b0;
    logic           pix_sof;
    logic           pix_eof;
    logic           irq;

    frame_reader_dma #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (FD)
    ) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .as_address       (as_address),
        .as_read          (as_read),
        .as_write         (as_write),
        .as_writedata     (as_writedata),
        .as_readdata      (as_readdata),
        .am_address       (am_address),
        .am_read          (am_read),
        .am_burstcount    (am_burstcount),
        .am_waitrequest   (am_waitrequest),
        .am_readdata      (am_readdata),
        .am_readdatavalid (am_readdatavalid),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_sof          (pix_sof),
        .pix_eof          (pix_eof),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DW+1:0] exp_pix[$];
    burst_t        exp_burst[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // ---------------- memory / fabric model ----------------
    int          cyc = 0;
    logic [31:0] ret_d[$];
    int          ret_t[$];
    int          last_t = 0;
    int          stall_cnt = 0;
    int          dly_min = 1;
    int          dly_max = 3;
    int          accepts = 0;
    bit          inject_stray = 1'b0;
    bit          prev_stall = 1'b0;
    logic [AW-1:0]  prev_addr;
    logic [BCW-1:0] prev_bc;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            ret_d.delete();
            ret_t.delete();
            am_waitrequest   = 1'b0;
            am_readdatavalid = 1'b0;
            prev_stall       = 1'b0;
        end else begin
            if (prev_stall) begin
                check("wr_hold_read", {63'd0, am_read}, 64'd1);
                check("wr_hold_addr", {32'd0, am_address}, {32'd0, prev_addr});
                check("wr_hold_bc", {60'd0, am_burstcount}, {60'd0, prev_bc});
            end
            am_waitrequest = am_read && (stall_cnt > 0);
            if (am_waitrequest) stall_cnt--;
            prev_stall = am_waitrequest;
            prev_addr  = am_address;
            prev_bc    = am_burstcount;
            if (am_read && !am_waitrequest) begin
                int d;
                accepts++;
                if (exp_burst.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_burst: got addr=0x%0h bc=%0d expected none", am_address, am_burstcount);
                end else begin
                    burst_t eb;
                    eb = exp_burst.pop_front();
                    check("burst_addr", {32'd0, am_address}, {32'd0, eb.addr});
                    check("burst_len", {60'd0, am_burstcount}, {60'd0, eb.bc});
                end
                d = $urandom_range(dly_max, dly_min);
                for (int k = 0; k < int'(am_burstcount); k++) begin
                    int t;
                    t = cyc + d + k;
                    if (t <= last_t) t = last_t + 1;
                    last_t = t;
                    ret_d.push_back(mem_word(am_address + 32'(4 * k)));
                    ret_t.push_back(t);
                end
            end
            if (inject_stray) begin
                am_readdatavalid = 1'b1;
                am_readdata      = 32'hDEAD_BEEF;
                inject_stray     = 1'b0;
            end else if (ret_t.size() > 0 && ret_t[0] <= cyc) begin
                am_readdatavalid = 1'b1;
                am_readdata      = ret_d.pop_front();
                void'(ret_t.pop_front());
            end else begin
                am_readdatavalid = 1'b0;
            end
        end
    end

    // ---------------- stream monitor ----------------
    int            ready_pct = 100;
    int            pix_seen = 0;
    bit            hold_prev = 1'b0;
    logic [DW+1:0] prev_word;

    always @(negedge clk) begin
        if (!reset_n) begin
            pix_ready = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {63'd0, pix_valid}, 64'd1);
                check("hold_word", {30'd0, pix_sof, pix_eof, pix_data}, {30'd0, prev_word});
            end
            pix_ready = ($urandom_range(99, 0) < ready_pct);
            if (pix_valid && pix_ready) begin
                pix_seen++;
                if (exp_pix.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pix: got 0x%0h expected none", pix_data);
                end else begin
                    check("pix_word", {30'd0, pix_sof, pix_eof, pix_data}, {30'd0, exp_pix.pop_front()});
                end
            end
            hold_prev = pix_valid && !pix_ready;
            prev_word = {pix_sof, pix_eof, pix_data};
            check("fifo_reserve",
                  {63'd0, (int'(u_dut.w_fifo_count) + int'(u_dut.r_outstanding)) <= FD}, 64'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        as_address   = a;
        as_writedata = d;
        as_write     = 1'b1;
        @(negedge clk);
        as_write     = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        as_address = a;
        as_read    = 1'b1;
        @(negedge clk);
        as_read    = 1'b0;
        d          = as_readdata;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        check(name, {32'd0, d}, {32'd0, exp});
    endtask

    task automatic expect_frame(input logic [31:0] base, input int len);
        for (int k = 0; k < len; k++)
            exp_pix.push_back({(k == 0), (k == len - 1), mem_word(base + 32'(4 * k))});
        for (int w = 0; w < len; w += BL)
            exp_burst.push_back('{addr: base + 32'(4 * w), bc: BCW'((len - w) < BL ? (len - w) : BL)});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_pix.size() != 0 || exp_burst.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout: got %0d words/%0d bursts pending expected 0", name, exp_pix.size(), exp_burst.size());
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int seen0;
        int n;

        repeat (3) @(negedge clk);
        check("rst_am_read", {63'd0, am_read}, 64'd0);
        check("rst_pix_valid", {63'd0, pix_valid}, 64'd0);
        check("rst_irq", {63'd0, irq}, 64'd0);
        reset_n = 1'b1;
        for (int r = 0; r < 4; r++)
            read_check("rst_reg", 2'(r), 32'd0);

        reg_write(REG_BASE, 32'h0000_1003);
        read_check("base_align", REG_BASE, 32'h0000_1000);

        // basic 20-word frame, bursts 8/8/4
        reg_write(REG_LENGTH, 32'd20);
        read_check("length_rd", REG_LENGTH, 32'd20);
        exp_burst.push_back('{addr: 32'h1000, bc: 4'd8});
        exp_burst.push_back('{addr: 32'h1020, bc: 4'd8});
        exp_burst.push_back('{addr: 32'h1040, bc: 4'd4});
        for (int k = 0; k < 20; k++)
            exp_pix.push_back({(k == 0), (k == 19), mem_word(32'h1000 + 32'(4 * k))});
        reg_write(REG_CTRL, 32'h1);
        read_check("status_busy", REG_STATUS, 32'h1);
        read_check("ctrl_start_rd0", REG_CTRL, 32'h0);
        wait_drain("basic", 1000);
        read_check("basic_status", REG_STATUS, 32'h2);
        reg_write(REG_STATUS, 32'h2);
        read_check("done_w1c", REG_STATUS, 32'h0);

        // waitrequest held on the first burst
        acc0 = accepts;
        stall_cnt = 5;
        reg_write(REG_BASE, 32'h3000);
        reg_write(REG_LENGTH, 32'd8);
        expect_frame(32'h3000, 8);
        reg_write(REG_CTRL, 32'h1);
        wait_drain("waitreq", 1000);
        check("waitreq_accepts", 64'(accepts - acc0), 64'd1);
        reg_write(REG_STATUS, 32'h2);

        // LENGTH=0: done next cycle, no reads
        acc0 = accepts;
        reg_write(REG_LENGTH, 32'd0);
        reg_write(REG_CTRL, 32'h5);
        check("len0_irq", {63'd0, irq}, 64'd1);
        check("len0_no_read", {63'd0, am_read}, 64'd0);
        read_check("len0_status", REG_STATUS, 32'h2);
        repeat (5) @(negedge clk);
        check("len0_accepts", 64'(accepts - acc0), 64'd0);
        reg_write(REG_STATUS, 32'h2);
        check("len0_irq_clr", {63'd0, irq}, 64'd0);
        reg_write(REG_CTRL, 32'h0);

        // LENGTH=1: single word carries sof and eof
        reg_write(REG_BASE, 32'h4000);
        reg_write(REG_LENGTH, 32'd1);
        exp_burst.push_back('{addr: 32'h4000, bc: 4'd1});
        exp_pix.push_back({1'b1, 1'b1, mem_word(32'h4000)});
        reg_write(REG_CTRL, 32'h1);
        wait_drain("len1", 1000);
        read_check("len1_status", REG_STATUS, 32'h2);
        reg_write(REG_STATUS, 32'h2);

        // backpressure with slow, jittery memory
        ready_pct = 30;
        dly_min = 1;
        dly_max = 10;
        reg_write(REG_BASE, 32'h8000);
        reg_write(REG_LENGTH, 32'd200);
        expect_frame(32'h8000, 200);
        reg_write(REG_CTRL, 32'h1);
        wait_drain("bp", 6000);
        read_check("bp_status", REG_STATUS, 32'h2);
        reg_write(REG_STATUS, 32'h2);
        ready_pct = 100;
        dly_max = 3;

        // continuous mode, BASE changed mid-frame, then continuous cleared
        reg_write(REG_BASE, 32'h1000);
        reg_write(REG_LENGTH, 32'd16);
        expect_frame(32'h1000, 16);
        expect_frame(32'h2000, 16);
        reg_write(REG_CTRL, 32'h7);
        reg_write(REG_BASE, 32'h2000);
        n = 0;
        while (exp_pix.size() > 16 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("cont_frame1_timeout", {63'd0, n >= 1000}, 64'd0);
        repeat (2) @(negedge clk);
        reg_write(REG_CTRL, 32'h4);
        wait_drain("cont", 1000);
        repeat (20) @(negedge clk);
        read_check("cont_status", REG_STATUS, 32'h2);
        check("cont_irq", {63'd0, irq}, 64'd1);
        reg_write(REG_STATUS, 32'h2);
        check("cont_irq_clr", {63'd0, irq}, 64'd0);
        read_check("cont_ctrl", REG_CTRL, 32'h4);

        // reset in the middle of a 64-word frame
        reg_write(REG_CTRL, 32'h0);
        reg_write(REG_BASE, 32'h5000);
        reg_write(REG_LENGTH, 32'd64);
        expect_frame(32'h5000, 64);
        seen0 = pix_seen;
        reg_write(REG_CTRL, 32'h1);
        n = 0;
        while (pix_seen < seen0 + 8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        reset_n = 1'b0;
        #1;
        check("mrst_outputs", {am_read, pix_valid, pix_sof, pix_eof, irq, 59'd0}, 64'd0);
        check("mrst_data", {am_burstcount, pix_data, 28'd0}, 64'd0);
        check("mrst_addr_rd", {am_address, as_readdata}, 64'd0);
        exp_pix.delete();
        exp_burst.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        inject_stray = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_ignored", {63'd0, pix_valid}, 64'd0);
        read_check("mrst_status", REG_STATUS, 32'h0);
        read_check("mrst_length", REG_LENGTH, 32'h0);
        reg_write(REG_BASE, 32'h6000);
        reg_write(REG_LENGTH, 32'd4);
        expect_frame(32'h6000, 4);
        reg_write(REG_CTRL, 32'h1);
        wait_drain("post_rst", 1000);
        read_check("post_rst_status", REG_STATUS, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
